// File: rtl/spi_mem_ctrl_pkg.sv
// Shared constants and types for the SPI-to-RAM command sequencer.
package spi_mem_pkg;

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RX_W   = CMD_W + DATA_W;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_REQ  = 2'd2,
        ST_READ_WAIT = 2'd3
    } state_t;

    // Receive word from the SPI slave: command in the top two bits, payload below.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] payload;
    } rx_word_t;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// SPI-side command/response and RAM-side strobe bundle for spi_mem_ctrl.
interface spi_mem_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 8
);
    import spi_mem_pkg::*;

    logic [RX_W-1:0]      rx_data;
    logic                 rx_valid;
    logic [DATA_W-1:0]    tx_data;
    logic                 tx_valid;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 busy;
    logic                 drop_err;

    // Environment side: SPI slave plus RAM.
    modport master (
        output rx_data, rx_valid, mem_rdata,
        input  tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, drop_err
    );

    // Controller side.
    modport slave (
        input  rx_data, rx_valid, mem_rdata,
        output tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, drop_err
    );

endinterface

// File: rtl/spi_mem_ctrl_rd_delay.sv
// mem_rd_delay: RD_LAT-deep valid shift register; o_capture marks the cycle
// in which mem_rdata belongs to the read issued when i_start was high.
module mem_rd_delay #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_capture
);

    logic [RD_LAT-1:0] r_sr;

    generate
        if (RD_LAT > 1) begin : g_multi
            // Shift the read marker one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[RD_LAT-2:0], i_start};
                end
            end
        end else begin : g_single
            // Single-stage latency: just register the marker.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_start;
                end
            end
        end
    endgenerate

    assign o_capture = r_sr[RD_LAT-1];

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes 10-bit SPI command words into single-port RAM
// accesses and returns read data for MISO.
// Optional: define SPI_MEM_AUTOINC_EN to post-increment the write address
// after each write and the read address after each read request.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_mem_ctrl_if.slave    bus
);

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_tx_valid;
    logic                 r_mem_en;
    logic                 r_mem_we;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_busy;
    logic                 r_drop_err;

    rx_word_t             w_rx;
    logic                 w_rd_start;
    logic                 w_capture;

    assign w_rx       = rx_word_t'(bus.rx_data);
    assign w_rd_start = (r_state == ST_READ_REQ);

    // Address increment that wraps at the top of the RAM.
    function automatic logic [ADDR_SIZE-1:0] f_addr_inc(input logic [ADDR_SIZE-1:0] a);
        if (a == ADDR_SIZE'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    // Read-latency tracker: fires in the cycle mem_rdata is to be sampled.
    mem_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_rd_start),
        .o_capture (w_capture)
    );

    // Command FSM with registered RAM strobes, response and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            if (bus.rx_valid && r_busy) begin
                r_drop_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        r_tx_valid <= 1'b0;
                        case (w_rx.cmd)
                            CMD_WR_ADDR: r_wr_addr <= ADDR_SIZE'(w_rx.payload);
                            CMD_WR_DATA: begin
                                r_state     <= ST_WRITE;
                                r_mem_en    <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_wr_addr;
                                r_mem_wdata <= w_rx.payload;
                                r_busy      <= 1'b1;
                            end
                            CMD_RD_ADDR: r_rd_addr <= ADDR_SIZE'(w_rx.payload);
                            CMD_RD_DATA: begin
                                r_state    <= ST_READ_REQ;
                                r_mem_en   <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= r_rd_addr;
                                r_busy     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
`ifdef SPI_MEM_AUTOINC_EN
                    r_wr_addr <= f_addr_inc(r_wr_addr);
`endif
                end
                ST_READ_REQ: begin
                    r_state <= ST_READ_WAIT;
`ifdef SPI_MEM_AUTOINC_EN
                    r_rd_addr <= f_addr_inc(r_rd_addr);
`endif
                end
                ST_READ_WAIT: begin
                    if (w_capture) begin
                        r_tx_data  <= bus.mem_rdata;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.drop_err  = r_drop_err;

endmodule
